// File: rtl/uart_rx_bit_sampler_pkg.sv
// Shared UART receiver definitions: parameter defaults, idle line level,
// the usual prescale ratios and the 3-sample majority helper.
package uart_rx_bit_sampler_pkg;

    localparam int PRESCALE_W_DEF = 6;
    localparam int BIT_CNT_W_DEF  = 4;
    localparam int FRAME_BITS_DEF = 11;   // start + 8 data + parity + stop

    localparam logic IDLE_LEVEL = 1'b1;   // UART line idles high

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge-within-bit and bit-within-frame counters for the RX oversampler.
// bit_done is decoded from the registered edge count so the bit counter
// and the edge wrap happen on the same clock edge.
module uart_rx_edge_bit_cnt
    import uart_rx_bit_sampler_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                  clk_RX,
    input  logic                  rst,
    input  logic                  samp_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    logic [PRESCALE_W-1:0] last_edge;

    // '>=' rather than '==' so an illegal or changed prescale can never
    // strand the counter above its wrap point.
    assign last_edge = prescale - PRESCALE_W'(1);
    assign bit_done  = samp_en && (edge_cnt >= last_edge);

    // Count edges within a bit and bits within a frame; clear while disabled.
    always_ff @(posedge clk_RX or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!samp_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_done) begin
            edge_cnt <= '0;
            bit_cnt  <= (bit_cnt >= LAST_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART RX oversampling front end: samples each bit around its centre and
// produces one resolved sampled_bit per bit period with a sample_valid pulse.
// Build option UART_RX_MAJORITY_VOTE_EN: 3-sample majority at edges
// mid-1/mid/mid+1 (result at mid+1); otherwise a single sample at edge mid.
module uart_rx_bit_sampler
    import uart_rx_bit_sampler_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                  clk_RX,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done,
    output logic                  sampled_bit,
    output logic                  sample_valid
);

    logic [PRESCALE_W-1:0] mid;
    logic                  resolve_pt;
    logic                  resolved;

    assign mid = prescale >> 1;

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W),
        .FRAME_BITS (FRAME_BITS)
    ) u_cnt (
        .clk_RX   (clk_RX),
        .rst      (rst),
        .samp_en  (samp_en),
        .prescale (prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [PRESCALE_W-1:0] mid_m1;
    logic [PRESCALE_W-1:0] mid_p1;
    logic                  s0;
    logic                  s1;

    assign mid_m1 = mid - PRESCALE_W'(1);
    assign mid_p1 = mid + PRESCALE_W'(1);

    // Capture the two early samples; the third is the live line at mid+1.
    always_ff @(posedge clk_RX or posedge rst) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else if (!samp_en) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            if (edge_cnt == mid_m1) s0 <= RX_IN;
            if (edge_cnt == mid)    s1 <= RX_IN;
        end
    end

    assign resolve_pt = samp_en && (edge_cnt == mid_p1);
    assign resolved   = majority3(s0, s1, RX_IN);
`else
    assign resolve_pt = samp_en && (edge_cnt == mid);
    assign resolved   = RX_IN;
`endif

    // Register the resolved bit and flag it valid in the following cycle.
    always_ff @(posedge clk_RX or posedge rst) begin
        if (rst) begin
            sampled_bit  <= IDLE_LEVEL;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= resolve_pt;
            if (resolve_pt) sampled_bit <= resolved;
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Self-checking bench for uart_rx_bit_sampler: table of frames plus hand
// sequences for enable drop and mid-frame reset; resolved bits go through
// a scoreboard queue popped on every sample_valid.
module tb_uart_rx_bit_sampler;
    import uart_rx_bit_sampler_pkg::*;

    localparam int PW = 6;
    localparam int BW = 4;
    localparam int FB = FRAME_BITS_DEF;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic          clk_RX = 1'b0;
    logic          rst = 1'b1;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          samp_en = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          bit_done;
    logic          sampled_bit;
    logic          sample_valid;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];
    logic hold_val = 1'b1;
    logic sb_e;

    typedef struct {
        int          p;
        logic [10:0] bits;
        bit          glitch;
        logic [10:0] exp;
    } vec_t;
    vec_t vecs[5];

    uart_rx_bit_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW), .FRAME_BITS(FB)) dut (
        .clk_RX       (clk_RX),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .samp_en      (samp_en),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .bit_done     (bit_done),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    always #5 clk_RX = ~clk_RX;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // frame bit 0 = start, 8:1 = data LSB first, 9 = even parity, 10 = stop
    function automatic logic [10:0] mk_frame(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    // scoreboard: every sample_valid pops one expected bit
    always @(negedge clk_RX) begin
        if (!rst && sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected at %0t: got sample_valid=1 expected none", $time);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_bit", int'(sampled_bit), int'(sb_e));
            end
        end
    end

    // Drive ncyc enabled cycles of a frame then tail idle cycles, checking
    // counters and pulses every cycle against the documented timing.
    task automatic run_frame(input int p, input logic [10:0] bits, input bit glitch,
                             input logic [10:0] exp, input int ncyc, input int tail);
        int   mid, lat, k, e;
        logic prev;
        mid  = p / 2;
        lat  = MAJ ? mid + 2 : mid + 1;
        prev = hold_val;
        prescale = p[PW-1:0];
        for (int b = 0; b < FB; b++) begin
            if (b * p + lat - 1 < ncyc) begin
                exp_q.push_back(exp[b]);
                hold_val = exp[b];
            end
        end
        for (int i = 0; i < ncyc + tail; i++) begin
            k = i / p;
            e = i % p;
            @(posedge clk_RX);
            #1;
            if (i < ncyc) begin
                samp_en = 1'b1;
                if (glitch && e == mid) RX_IN = 1'b1;
                else                    RX_IN = bits[k];
            end else begin
                samp_en = 1'b0;
                RX_IN   = 1'b1;
            end
            @(negedge clk_RX);
            if (i <= ncyc) begin
                chk("edge_cnt", int'(edge_cnt), e);
                chk("bit_cnt", int'(bit_cnt), k % FB);
            end else begin
                chk("edge_cnt_idle", int'(edge_cnt), 0);
                chk("bit_cnt_idle", int'(bit_cnt), 0);
            end
            chk("bit_done", int'(bit_done), int'(i < ncyc && e == p - 1));
            chk("sample_valid", int'(sample_valid),
                int'(i >= lat && i <= ncyc && (i - lat) % p == 0));
            if (i < lat)  chk("hold_pre", int'(sampled_bit), int'(prev));
            if (i > ncyc) chk("hold_post", int'(sampled_bit), int'(hold_val));
        end
    endtask

    initial begin
        logic [10:0] f;

        // reset held with line toggling and enable high: nothing moves
        samp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_RX);
            #1 RX_IN = ~RX_IN;
            @(negedge clk_RX);
            chk("rst_sampled_bit", int'(sampled_bit), 1);
            chk("rst_edge_cnt", int'(edge_cnt), 0);
            chk("rst_bit_cnt", int'(bit_cnt), 0);
            chk("rst_bit_done", int'(bit_done), 0);
            chk("rst_sample_valid", int'(sample_valid), 0);
        end
        @(posedge clk_RX);
        #1;
        rst = 1'b0;
        samp_en = 1'b0;
        RX_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_RX);
            chk("idle_sampled_bit", int'(sampled_bit), 1);
            chk("idle_edge_cnt", int'(edge_cnt), 0);
            chk("idle_sample_valid", int'(sample_valid), 0);
        end

        // table of frames
        f = mk_frame(8'h55);
        vecs[0] = '{8, f, 1'b0, f};
        f = mk_frame(8'h00);
        vecs[1] = '{16, f, 1'b1, (MAJ ? f : 11'h7ff)};
        f = mk_frame(8'hA3);
        vecs[2] = '{4, f, 1'b0, f};
        f = mk_frame(8'h3C);
        vecs[3] = '{32, f, 1'b0, f};
        f = mk_frame(8'hE1);
        vecs[4] = '{16, f, 1'b0, f};
        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].p, vecs[v].bits, vecs[v].glitch, vecs[v].exp, FB * vecs[v].p, 2);

        // enable dropped at edge 3 of bit 4, back after 5 cycles
        f = mk_frame(8'h0F);
        run_frame(8, f, 1'b0, f, 4 * 8 + 3, 5);
        f = mk_frame(8'hC5);
        run_frame(8, f, 1'b0, f, FB * 8, 2);

        // reset pulsed at edge 5 of bit 2
        f = mk_frame(8'h96);
        run_frame(8, f, 1'b0, f, 2 * 8 + 5, 0);
        @(posedge clk_RX);
        #1;
        samp_en = 1'b1;
        RX_IN = f[2];
        chk("pre_rst_edge_cnt", int'(edge_cnt), 5);
        chk("pre_rst_bit_cnt", int'(bit_cnt), 2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_edge_cnt", int'(edge_cnt), 0);
        chk("async_rst_bit_cnt", int'(bit_cnt), 0);
        chk("async_rst_sampled_bit", int'(sampled_bit), 1);
        chk("async_rst_sample_valid", int'(sample_valid), 0);
        chk("async_rst_bit_done", int'(bit_done), 0);
        exp_q.delete();
        hold_val = 1'b1;
        samp_en = 1'b0;
        @(negedge clk_RX);
        rst = 1'b0;
        f = mk_frame(8'h3A);
        run_frame(8, f, 1'b0, f, FB * 8, 2);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
